// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander. It loads one 512-bit block, expands W16..W63
// at one word per clock from a 16-word sliding window, and presents the 64-word vector.
//   state  | meaning
//   IDLE   | ready for a block; w/h hold the previous result
//   EXPAND | writing W[t], t = 16..63, one word per clock
//   DONE   | result valid, waiting for out_ready
module sha256_msg_sched #(
  parameter bit BYTE_SWAP = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [511:0]  block,
  input  logic [255:0]  h_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2047:0] w,
  output logic [31:0]   h1,
  output logic [31:0]   h2,
  output logic [31:0]   h3,
  output logic [31:0]   h4,
  output logic [31:0]   h5,
  output logic [31:0]   h6,
  output logic [31:0]   h7,
  output logic [31:0]   h8
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state, state_nxt;
  logic [6:0]  t;
  logic [31:0] win [16];
  logic [31:0] m_ld [16];
  logic [31:0] w_new;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // win[0] is W[t-16], win[15] is W[t-1]
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      m_ld[i] = BYTE_SWAP ? bswap(block[(15-i)*32 +: 32]) : block[(15-i)*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EXPAND;
      EXPAND:  if (t == 7'd63) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t  <= '0;
      w  <= '0;
      h1 <= '0;
      h2 <= '0;
      h3 <= '0;
      h4 <= '0;
      h5 <= '0;
      h6 <= '0;
      h7 <= '0;
      h8 <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            t <= 7'd16;
            for (int i = 0; i < 16; i++) begin
              win[i]         <= m_ld[i];
              w[i*32 +: 32]  <= m_ld[i];
            end
            h1 <= h_in[255:224];
            h2 <= h_in[223:192];
            h3 <= h_in[191:160];
            h4 <= h_in[159:128];
            h5 <= h_in[127:96];
            h6 <= h_in[95:64];
            h7 <= h_in[63:32];
            h8 <= h_in[31:0];
          end
        end
        EXPAND: begin
          for (int i = 0; i < 15; i++) win[i] <= win[i+1];
          win[15] <= w_new;
          for (int i = 16; i < 64; i++) begin
            if (t == 7'(i)) w[i*32 +: 32] <= w_new;
          end
          t <= t + 7'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
